sh_wdt_win: RTL and testbench

Parametrised watchdog/interval timer for the SH-family on-chip peripheral bus, the next generation of the 8-bit SH7034 WDT. It generalises counter width, address base and output pulse lengths, and adds an optional windowed-watchdog mode that treats a premature kick as a fault. It sits on the internal IBUS beside the other timers, drives the interval IRQ to the interrupt controller, and drives the power-on/manual reset requests to the reset controller.

---
 rtl/sh_wdt_win_if.sv | 16 +
 rtl/sh_wdt_win.sv | 120 ++++++++++++
 tb/tb_sh_wdt_win.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sh_wdt_win_if.sv
// sh_wdt_win_if: IBUS slave port bundle for the SH watchdog/interval timer
//   IBUS_A    address (byte)          IBUS_DI   write data
//   IBUS_DO   registered read data    IBUS_WE   write strobe
//   IBUS_REQ  request                 IBUS_BUSY never busy
//   IBUS_ACT  address hits the timer register block
interface sh_wdt_win_if;
    logic [27:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;
    modport master (output IBUS_A, IBUS_DI, IBUS_WE, IBUS_REQ, input IBUS_DO, IBUS_BUSY, IBUS_ACT);
    modport slave (input IBUS_A, IBUS_DI, IBUS_WE, IBUS_REQ, output IBUS_DO, IBUS_BUSY, IBUS_ACT);
endinterface

// File: rtl/sh_wdt_win.sv
// sh_wdt_win: parametrised SH watchdog/interval timer with optional windowed watchdog
//   CLK, RST      clock, synchronous active-high reset
//   CE            clock enable for all state
//   RES_N         soft reset (low = init, qualified by CE)
//   PSC_CE[7:0]   prescaler strobes selected by CSR.CKS
//   ibus          IBUS slave port (register block at BASE, 3 words)
//   WDTOVF_N      watchdog overflow pulse, OVF_CYC cycles low
//   ITI_IRQ       interval interrupt (CSR.OVF)
//   PRES, MRES    power-on / manual reset request, RES_CYC cycles high
//   Macro SH_WDT_WINDOW_EN adds the WIN register and premature-kick fault.
module sh_wdt_win #(
    parameter int          CNT_W   = 8,
    parameter logic [27:0] BASE    = 28'h5FFFFB8,
    parameter int          OVF_CYC = 128,
    parameter int          RES_CYC = 512
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        RES_N,
    input  logic [7:0]  PSC_CE,
    sh_wdt_win_if.slave ibus,
    output logic        WDTOVF_N,
    output logic        ITI_IRQ,
    output logic        PRES,
    output logic        MRES
);
    localparam int OW = OVF_CYC > 1 ? $clog2(OVF_CYC) : 1;
    localparam int RW = RES_CYC > 1 ? $clog2(RES_CYC) : 1;
    localparam logic [OW-1:0] OVF_LD = OW'(OVF_CYC - 1);
    localparam logic [RW-1:0] RES_LD = RW'(RES_CYC - 1);
    logic [CNT_W-1:0] cnt, win;
    logic             ovf, wt, tme;
    logic [2:0]       cks;
    logic             wovf, rste, rsts, werr;
    logic             tick, ovf_act, res_act, res_m;
    logic [OW-1:0]    ovf_cnt;
    logic [RW-1:0]    res_cnt;
    logic [31:0]      do_q, rdata;
    logic [27:0]      off;
    logic [7:0]       key;
    logic             init, sel, wr, kick, csr_wr, rst_set, rst_clr, premature, wrap, wd_ev, it_ev;
    logic             unused_di;
    assign init      = RST || (CE && !RES_N);
    assign off       = ibus.IBUS_A - BASE;
    assign sel       = ibus.IBUS_A >= BASE && off < 28'd12;
    assign key       = ibus.IBUS_DI[31:24];
    assign wr        = ibus.IBUS_REQ && ibus.IBUS_WE && sel;
    assign kick      = wr && off[3:2] == 2'd0 && key == 8'h5A;
    assign csr_wr    = wr && off[3:2] == 2'd0 && key == 8'hA5;
    assign rst_set   = wr && off[3:2] == 2'd1 && key == 8'h5A;
    assign rst_clr   = wr && off[3:2] == 2'd1 && key == 8'hA5 && !ibus.IBUS_DI[7];
    assign wrap      = tick && &cnt;
    assign wd_ev     = (wrap && wt) || premature;
    assign it_ev     = wrap && !wt;
    assign unused_di = ^ibus.IBUS_DI;
    assign rdata = off[3:2] == 2'd0 ? {ovf, wt, tme, 2'b11, cks, 8'h00, 16'(cnt)} :
                   off[3:2] == 2'd1 ? {wovf, rste, rsts, werr, 4'hF, 24'h0} :
                   off[3:2] == 2'd2 ? 32'(win) : 32'h0;
`ifdef SH_WDT_WINDOW_EN
    always_ff @(posedge CLK)
        if (init) win <= '0;
        else if (CE && wr && off[3:2] == 2'd2) win <= ibus.IBUS_DI[CNT_W-1:0];
    // A kick inside the closed window counts as a watchdog fault.
    assign premature = kick && wt && tme && win != '0 && cnt < win;
`else
    assign win       = '0;
    assign premature = 1'b0;
`endif
    always_ff @(posedge CLK) begin
        if (init) begin
            cnt     <= '0;
            {ovf, wt, tme, cks} <= '0;
            {wovf, rste, rsts, werr} <= '0;
            tick    <= 1'b0;
            do_q    <= '0;
            ovf_act <= 1'b0;
            ovf_cnt <= '0;
            res_act <= 1'b0;
            res_cnt <= '0;
            res_m   <= 1'b0;
        end else if (CE) begin
            tick <= PSC_CE[cks];
            do_q <= ibus.IBUS_REQ && sel ? rdata : '0;
            if (kick && !premature) cnt <= ibus.IBUS_DI[CNT_W-1:0];
            else if (tick) cnt <= tme ? cnt + 1'b1 : '0;
            if (wd_ev) {ovf, wt, tme, cks} <= '0;
            else begin
                if (csr_wr) {wt, tme, cks} <= {ibus.IBUS_DI[6:5], ibus.IBUS_DI[2:0]};
                ovf <= it_ev || (ovf && !(csr_wr && !ibus.IBUS_DI[7]));
            end
            if (rst_set) {rste, rsts} <= ibus.IBUS_DI[6:5];
            wovf <= wd_ev || (wovf && !rst_clr);
            werr <= premature || (werr && !rst_clr);
            // Pulse lasts while active; the counter runs LD..0 inclusive.
            if (wd_ev) begin
                ovf_act <= 1'b1;
                ovf_cnt <= OVF_LD;
            end else if (ovf_act) begin
                ovf_act <= ovf_cnt != '0;
                ovf_cnt <= ovf_cnt - 1'b1;
            end
            if (wd_ev && rste) begin
                res_act <= 1'b1;
                res_cnt <= RES_LD;
                res_m   <= rsts;
            end else if (res_act) begin
                res_act <= res_cnt != '0;
                res_cnt <= res_cnt - 1'b1;
            end
        end
    end
    assign WDTOVF_N       = !ovf_act;
    assign PRES           = res_act && !res_m;
    assign MRES           = res_act && res_m;
    assign ITI_IRQ        = ovf;
    assign ibus.IBUS_DO   = do_q;
    assign ibus.IBUS_BUSY = 1'b0;
    assign ibus.IBUS_ACT  = sel;
endmodule

// File: tb/tb_sh_wdt_win.sv
// tb_sh_wdt_win: randomized and directed self-checking bench for sh_wdt_win against a byte-level model
module tb_sh_wdt_win;
    localparam int          CW   = 8;
    localparam logic [27:0] BASE = 28'h5FFFFB8;
    localparam int          OC   = 128;
    localparam int          RC   = 512;
    logic       CLK = 1'b0, RST = 1'b1, CE = 1'b1, RES_N = 1'b1;
    logic [7:0] PSC_CE = 8'h00;
    logic       WDTOVF_N, ITI_IRQ, PRES, MRES;
    int         checks = 0, errors = 0;
    sh_wdt_win_if bus();
    sh_wdt_win #(.CNT_W(CW), .BASE(BASE), .OVF_CYC(OC), .RES_CYC(RC)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .RES_N(RES_N), .PSC_CE(PSC_CE), .ibus(bus),
        .WDTOVF_N(WDTOVF_N), .ITI_IRQ(ITI_IRQ), .PRES(PRES), .MRES(MRES)
    );
    always #5 CLK = ~CLK;
    // Model: CSR and RSTCSR kept as the bytes software sees; pulses as remaining-cycle counts.
    int unsigned m_cnt, m_win;
    logic [7:0]  m_csr, m_rst;
    bit          m_tick, m_mres;
    int          m_ovf_left, m_res_left;
    logic [31:0] m_do;
    task automatic m_init();
        m_cnt = 0; m_win = 0; m_csr = 8'h18; m_rst = 8'h0F; m_tick = 0;
        m_mres = 0; m_ovf_left = 0; m_res_left = 0; m_do = 0;
    endtask
    task automatic m_step();
        int unsigned maxc = (1 << CW) - 1;
        bit          act = bus.IBUS_A >= BASE && bus.IBUS_A <= BASE + 28'd11;
        int          w = int'(bus.IBUS_A - BASE) / 4;
        logic [31:0] di = bus.IBUS_DI;
        logic [7:0]  key = di[31:24];
        bit          wr = act && bus.IBUS_REQ && bus.IBUS_WE;
        bit          full = m_tick && m_cnt == maxc;
        bit          wt = m_csr[6];
        bit          tme = m_csr[5];
        bit          kick = wr && w == 0 && key == 8'h5A;
        bit          early = 0;
        bit          wd;
        logic [7:0]  n_csr = m_csr;
        logic [7:0]  n_rst = m_rst;
        logic [31:0] rd;
`ifdef SH_WDT_WINDOW_EN
        early = kick && wt && tme && m_win != 0 && m_cnt < m_win;
`endif
        wd = (full && wt) || early;
        rd = w == 0 ? {m_csr, 8'h00, 16'(m_cnt)} : w == 1 ? {m_rst, 24'h0} : 32'(m_win);
        m_do = (bus.IBUS_REQ && act) ? rd : 32'h0;
        if (kick && !early) m_cnt = di & maxc;
        else if (m_tick) m_cnt = tme ? (m_cnt + 1) & maxc : 0;
        if (wr && w == 0 && key == 8'hA5) n_csr = {m_csr[7] & di[7], di[6:0]} | 8'h18;
        if (full && !wt) n_csr[7] = 1'b1;
        if (wd) n_csr = 8'h18;
        if (wr && w == 1 && key == 8'h5A) n_rst[6:5] = di[6:5];
        if (wr && w == 1 && key == 8'hA5 && !di[7]) begin n_rst[7] = 1'b0; n_rst[4] = 1'b0; end
        if (wd) n_rst[7] = 1'b1;
        if (early) n_rst[4] = 1'b1;
        if (m_ovf_left > 0) m_ovf_left--;
        if (m_res_left > 0) m_res_left--;
        if (wd) m_ovf_left = OC;
        if (wd && m_rst[6]) begin m_res_left = RC; m_mres = m_rst[5]; end
`ifdef SH_WDT_WINDOW_EN
        if (wr && w == 2) m_win = di & maxc;
`endif
        m_tick = PSC_CE[m_csr[2:0]];
        m_csr = n_csr;
        m_rst = n_rst;
    endtask
    always @(posedge CLK) begin
        if (RST || (CE && !RES_N)) m_init();
        else if (CE) m_step();
    end
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    always @(negedge CLK) begin
        chk("ibus_do", bus.IBUS_DO, m_do);
        chk("wdtovf_n", 32'(WDTOVF_N), 32'(m_ovf_left == 0));
        chk("pres", 32'(PRES), 32'(m_res_left > 0 && !m_mres));
        chk("mres", 32'(MRES), 32'(m_res_left > 0 && m_mres));
        chk("iti_irq", 32'(ITI_IRQ), 32'(m_csr[7]));
        chk("ibus_busy", 32'(bus.IBUS_BUSY), 32'h0);
        chk("ibus_act", 32'(bus.IBUS_ACT), 32'(bus.IBUS_A >= BASE && bus.IBUS_A <= BASE + 28'd11));
    end
    task automatic idle(int n);
        repeat (n) begin @(negedge CLK); #1; end
    endtask
    task automatic wr(int w, logic [31:0] d);
        bus.IBUS_A = BASE + 28'(4 * w); bus.IBUS_DI = d; bus.IBUS_REQ = 1'b1; bus.IBUS_WE = 1'b1;
        idle(1);
        bus.IBUS_REQ = 1'b0; bus.IBUS_WE = 1'b0;
    endtask
    task automatic rd(int w, logic [31:0] exp, string name);
        bus.IBUS_A = BASE + 28'(4 * w); bus.IBUS_REQ = 1'b1; bus.IBUS_WE = 1'b0;
        @(negedge CLK);
        chk(name, bus.IBUS_DO, exp);
        #1 bus.IBUS_REQ = 1'b0;
    endtask
    task automatic strobe();
        PSC_CE = 8'h01;
        idle(1);
        PSC_CE = 8'h00;
    endtask
    task automatic pulses(output int nl, output int np, output int nm);
        nl = 0; np = 0; nm = 0;
        repeat (700) begin
            @(negedge CLK);
            nl += int'(!WDTOVF_N); np += int'(PRES); nm += int'(MRES);
        end
        #1;
    endtask
    initial begin
        int nl, np, nm;
        bus.IBUS_A = 28'h0; bus.IBUS_DI = 32'h0; bus.IBUS_REQ = 1'b0; bus.IBUS_WE = 1'b0;
        idle(3);
        chk("rst_do", bus.IBUS_DO, 32'h0);
        chk("rst_wdtovf_n", 32'(WDTOVF_N), 32'h1);
        chk("rst_pres_mres", 32'({PRES, MRES}), 32'h0);
        chk("rst_iti", 32'(ITI_IRQ), 32'h0);
        RST = 1'b0;
        rd(0, 32'h1800_0000, "rst_csr");
        rd(1, 32'h0F00_0000, "rst_rstcsr");
        rd(2, 32'h0, "rst_win");
        // interval mode overflow and clear
        wr(0, 32'hA500_0020);
        wr(0, 32'h5A00_00FE);
        strobe();
        strobe();
        chk("iti_before", 32'(ITI_IRQ), 32'h0);
        idle(1);
        chk("iti_set", 32'(ITI_IRQ), 32'h1);
        rd(0, 32'hB800_0000, "iti_csr_cnt");
        wr(0, 32'hA500_0020);
        chk("iti_clr", 32'(ITI_IRQ), 32'h0);
        // watchdog, power-on reset request
        wr(1, 32'h5A00_0040);
        wr(0, 32'hA500_0060);
        wr(0, 32'h5A00_00FF);
        strobe();
        pulses(nl, np, nm);
        chk("wd_ovf_len", nl, OC);
        chk("wd_pres_len", np, RC);
        chk("wd_mres_len", nm, 0);
        rd(1, 32'hCF00_0000, "wd_rstcsr");
        rd(0, 32'h1800_0000, "wd_csr");
        // watchdog, manual reset request
        wr(1, 32'hA500_0000);
        wr(1, 32'h5A00_0060);
        wr(0, 32'hA500_0060);
        wr(0, 32'h5A00_00FF);
        strobe();
        pulses(nl, np, nm);
        chk("mr_ovf_len", nl, OC);
        chk("mr_pres_len", np, 0);
        chk("mr_mres_len", nm, RC);
        // watchdog, no reset request
        wr(1, 32'hA500_0000);
        wr(1, 32'h5A00_0000);
        wr(0, 32'hA500_0060);
        wr(0, 32'h5A00_00FF);
        strobe();
        pulses(nl, np, nm);
        chk("nr_ovf_len", nl, OC);
        chk("nr_res_len", np + nm, 0);
        // bad key ignored; kick beats a coincident tick
        wr(0, 32'hA500_0020);
        wr(0, 32'h5A00_0012);
        wr(0, 32'h3300_0077);
        rd(0, 32'h3800_0012, "badkey");
        PSC_CE = 8'h01;
        idle(1);
        PSC_CE = 8'h00;
        wr(0, 32'h5A00_0034);
        rd(0, 32'h3800_0034, "kick_vs_tick");
        wr(1, 32'hA500_0000);
`ifdef SH_WDT_WINDOW_EN
        wr(2, 32'h0000_0080);
        rd(2, 32'h0000_0080, "win_rd");
        wr(0, 32'h5A00_0040);
        wr(0, 32'hA500_0060);
        wr(0, 32'h5A00_0055);
        chk("win_early_ovf", 32'(WDTOVF_N), 32'h0);
        rd(1, 32'h9F00_0000, "win_early_rstcsr");
        rd(0, 32'h1800_0040, "win_early_cnt");
        wr(1, 32'hA500_0000);
        wr(0, 32'hA500_0020);
        wr(0, 32'h5A00_0090);
        wr(0, 32'hA500_0060);
        wr(0, 32'h5A00_0011);
        rd(0, 32'h7800_0011, "win_ok_cnt");
        rd(1, 32'h0F00_0000, "win_ok_rstcsr");
`else
        wr(2, 32'h0000_0080);
        rd(2, 32'h0, "win_rd");
        wr(0, 32'h5A00_0040);
        wr(0, 32'hA500_0060);
        wr(0, 32'h5A00_0055);
        rd(0, 32'h7800_0055, "nowin_kick");
        rd(1, 32'h0F00_0000, "nowin_rstcsr");
`endif
        // reset during a PRES pulse
        idle(150);
        wr(1, 32'hA500_0000);
        wr(1, 32'h5A00_0040);
        wr(0, 32'hA500_0060);
        wr(0, 32'h5A00_00FF);
        strobe();
        idle(60);
        chk("mid_pres", 32'(PRES), 32'h1);
        chk("mid_wdtovf_n", 32'(WDTOVF_N), 32'h0);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_pres", 32'(PRES), 32'h0);
        chk("abort_wdtovf_n", 32'(WDTOVF_N), 32'h1);
        #1 RST = 1'b0;
        rd(0, 32'h1800_0000, "abort_csr");
        rd(1, 32'h0F00_0000, "abort_rstcsr");
        // randomized traffic against the model
        for (int i = 0; i < 5000; i++) begin
            logic [7:0] k;
            int         ks = $urandom_range(0, 9);
            k = ks < 4 ? 8'h5A : ks < 8 ? 8'hA5 : 8'($urandom);
            CE = $urandom_range(0, 99) < 92;
            RES_N = $urandom_range(0, 399) != 0;
            RST = $urandom_range(0, 1499) == 0;
            PSC_CE = 8'($urandom) & 8'($urandom);
            bus.IBUS_REQ = $urandom_range(0, 2) == 0;
            bus.IBUS_WE = 1'($urandom_range(0, 1));
            bus.IBUS_A = BASE - 28'd4 + 28'(4 * $urandom_range(0, 4));
            bus.IBUS_DI = {k, 16'($urandom), $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom)};
            idle(1);
        end
        RST = 1'b0; CE = 1'b1; RES_N = 1'b1; bus.IBUS_REQ = 1'b0;
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
